// File: rtl/fft_output_serializer_if.sv
// Beat-stream bundle for the FFT output serializer.
// The master side is the serializer; the slave side supplies frames and ready.
interface fft_output_serializer_if;
  logic                   stage3_done;
  logic [0:7][11:0]       x_stage3_real;
  logic [0:7][11:0]       x_stage3_image;
  logic                   out_ready;
  logic                   out_valid;
  logic signed [11:0]     out_real;
  logic signed [11:0]     out_image;
  logic [2:0]             out_index;
  logic                   out_last;

  modport master (
    input  stage3_done, x_stage3_real, x_stage3_image, out_ready,
    output out_valid, out_real, out_image, out_index, out_last
  );

  modport slave (
    output stage3_done, x_stage3_real, x_stage3_image, out_ready,
    input  out_valid, out_real, out_image, out_index, out_last
  );
endinterface

// File: rtl/fft_output_serializer.sv
// Turns 8-point FFT frames into a valid/ready beat stream, one complex bin per beat,
// with a one-deep pending frame queue and a sticky overrun flag on drops.
module fft_output_serializer #(
  parameter bit BITREV = 1'b1
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic clr_overrun,
  fft_output_serializer_if.master io,
  output logic busy,
  output logic overrun
);
  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic             pend_full_q, pend_full_d;
  logic             ovr_d;
  logic             ld_act_new, ld_act_pend, ld_pend;
  logic             xfer, frame_end;
  logic [2:0]       rd_idx;
  logic [0:7][11:0] act_re, act_im, pend_re, pend_im;

  assign xfer      = (state_q == STREAM) && io.out_ready;
  assign frame_end = xfer && (k_q == 3'd7);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      pend_full_q <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      pend_full_q <= pend_full_d;
      overrun     <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    pend_full_d = pend_full_q;
    ld_act_new  = 1'b0;
    ld_act_pend = 1'b0;
    ld_pend     = 1'b0;
    ovr_d       = overrun & ~clr_overrun;
    case (state_q)
      IDLE: begin
        if (io.stage3_done) begin
          ld_act_new = 1'b1;
          k_d        = 3'd0;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        // k wraps 7 -> 0 on the final transfer, ready for the next frame
        if (xfer) k_d = k_q + 3'd1;
        if (frame_end) begin
          if (pend_full_q) begin
            ld_act_pend = 1'b1;
            ld_pend     = io.stage3_done;
            pend_full_d = io.stage3_done;
          end else if (io.stage3_done) begin
            ld_act_new = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (io.stage3_done) begin
          if (pend_full_q) begin
            ovr_d = 1'b1;
          end else begin
            ld_pend     = 1'b1;
            pend_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame storage is never reset; its contents are masked while IDLE.
  always_ff @(posedge CLK) begin
    if (ld_act_new) begin
      act_re <= io.x_stage3_real;
      act_im <= io.x_stage3_image;
    end else if (ld_act_pend) begin
      act_re <= pend_re;
      act_im <= pend_im;
    end
    if (ld_pend) begin
      pend_re <= io.x_stage3_real;
      pend_im <= io.x_stage3_image;
    end
  end

  assign rd_idx       = BITREV ? {k_q[0], k_q[1], k_q[2]} : k_q;
  assign io.out_valid = (state_q == STREAM);
  assign io.out_real  = io.out_valid ? act_re[rd_idx] : 12'sd0;
  assign io.out_image = io.out_valid ? act_im[rd_idx] : 12'sd0;
  assign io.out_index = k_q;
  assign io.out_last  = io.out_valid && (k_q == 3'd7);
  assign busy         = io.out_valid;
endmodule

// File: doc/fft_output_serializer.md
FFT_OUTPUT_SERIALIZER -- requirements
Module: fft_output_serializer

Interface
REQ-001 Parameter BITREV, default 1; when 1, beats are emitted in natural frequency order by reading the buffer in bit-reversed index order; when 0, beats are emitted in buffer order.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 nRESET  input  1  asynchronous, active-low reset.
REQ-004 stage3_done  input  1  one-cycle pulse; the frame on x_stage3_real/x_stage3_image is valid this cycle.
REQ-005 x_stage3_real  input  signed 12 x [0:7]  FFT real outputs, Q8.4.
REQ-006 x_stage3_image  input  signed 12 x [0:7]  FFT imaginary outputs, Q8.4.
REQ-007 out_ready  input  1  downstream accepts a beat.
REQ-008 clr_overrun  input  1  synchronous clear of the overrun flag.
REQ-009 out_valid  output  1  beat available.
REQ-010 out_real, out_image  output  signed 12 each  beat data, Q8.4, passed through unmodified.
REQ-011 out_index  output  3  frequency bin index k of the current beat.
REQ-012 out_last  output  1  high with out_valid when k = 7.
REQ-013 busy  output  1  high when the active buffer holds a frame.
REQ-014 overrun  output  1  sticky flag; a frame was dropped.

Function
REQ-015 Storage is two 8-entry complex frame buffers: ACTIVE (being streamed) and PENDING (one-deep queue).
REQ-016 FSM has two states:
- IDLE: out_valid = 0.
- STREAM: out_valid = 1.
REQ-017 Capture: with stage3_done high, the block samples all 16 words at that edge and does not read the inputs in any other cycle.
REQ-018 In IDLE, stage3_done loads ACTIVE, sets k = 0 and enters STREAM; out_valid is high in the next cycle (latency 1).
REQ-019 Beat data: out_real/out_image = ACTIVE[BITREV ? bitrev(k) : k], where bitrev(0..7) = 0,4,2,6,1,5,3,7; out_index = k.
REQ-020 Handshake: a transfer occurs when out_valid and out_ready are both high.
- On transfer, k increments.
- Without a transfer, out_valid, out_real, out_image, out_index and out_last hold stable.
- out_valid does not depend combinationally on out_ready.
REQ-021 Transfer at k = 7 (frame end):
- If PENDING is full, it moves to ACTIVE, k = 0, the FSM stays in STREAM and out_valid stays high with no bubble.
- Otherwise the FSM returns to IDLE.
REQ-022 stage3_done while in STREAM:
- If the frame is not ending this cycle and PENDING is empty, the new frame loads into PENDING.
- If the frame is ending this cycle and PENDING is empty, the new frame loads directly into ACTIVE with k = 0 and the FSM stays in STREAM.
- If the frame is ending this cycle and PENDING is full, PENDING moves to ACTIVE and the new frame loads into PENDING; no drop.
- If the frame is not ending this cycle and PENDING is full, the new frame is discarded and overrun is set.
REQ-023 overrun is set as in REQ-022 and cleared by clr_overrun; if set and clear occur in the same cycle, set wins.
REQ-024 busy = (state == STREAM).
REQ-025 No arithmetic, rounding or saturation is applied; data bits are transported exactly.

Reset
REQ-026 nRESET low asynchronously forces state IDLE, k = 0, PENDING empty, out_valid = 0, out_last = 0, busy = 0, overrun = 0, out_real = 0, out_image = 0, out_index = 0.
REQ-027 Reset asserted mid-frame discards both buffers; after release, nothing is emitted until the next stage3_done.
REQ-028 Buffer contents need no reset; they are unobservable while out_valid = 0.

Verification
REQ-029 Single frame, out_ready held 1, real[i] = 16*i, image[i] = -16*i, BITREV = 1:
- out_valid rises 1 cycle after stage3_done.
- 8 consecutive beats with out_index 0..7 and out_real = 0,64,32,96,16,80,48,112.
- out_last is high only on the 8th beat.
- busy drops after the 8th beat.
REQ-030 Backpressure, same frame, out_ready toggling 1,0,0,1,...:
- Data, index and out_last hold stable during stalls.
- No beat is lost or duplicated; the total is 8 transfers.
REQ-031 Back-to-back frames A and B, with stage3_done pulses 3 cycles apart and out_ready = 1:
- B is queued in PENDING.
- B's beat 0 follows A's beat 7 in the next cycle with out_valid continuously high (16 beats, no bubble).
REQ-032 Overrun: out_ready = 0, then 3 stage3_done pulses (A, B, C):
- overrun becomes 1 after C.
- Once out_ready = 1, exactly A then B are emitted.
- clr_overrun clears the flag; a clear in the same cycle as a new drop leaves overrun = 1.
REQ-033 Frame-end collision: stage3_done coincides with the transfer of beat 7, first with PENDING empty and then with PENDING full:
- No overrun in either case.
- Ordering is preserved.
REQ-034 Reset at beat 3 of a frame:
- Outputs go to 0 immediately, without waiting for a clock edge.
- After release, out_valid stays 0 until a new stage3_done.
- The next frame streams from out_index 0.
